// File: rtl/sram_arbiter_ctrl.sv
// sram_arbiter_ctrl
//   Two-requester round-robin arbiter and timing sequencer for an external
//   64-bit asynchronous SRAM bank (four x16 devices sharing address/control).
//   Each granted request runs to completion. Completion is reported by a
//   one-cycle readyN pulse on the granted port.
//
// Ports
//   clk, rst                  clock (rising edge) / async active-high reset
//   reqN_valid/rw/addr/wdata  request from requester N (rw: 1=write, 0=read)
//   reqN_ready                one-cycle completion pulse for requester N
//   reqN_rdata                shared read-data register, valid with own ready
//   CE_N/OE_N/WE_N/LB_N/UB_N  active-low SRAM controls
//   mem_addr                  registered SRAM word address
//   mem_data                  bidirectional SRAM data, driven only while writing
module sram_arbiter_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 64,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              LB_N,
  output logic              UB_N,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

  typedef enum logic [2:0] {
    IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                id_reg;
  logic                last_grant_reg;

  logic                grant_valid;
  logic                grant_id;
  logic                grant_rw;
  logic                take_grant;
  logic                bus_drive;

  // Round-robin: on contention the port that did not win last time is chosen.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_reg;
    end else begin
      grant_id = ~req0_valid;
    end
    grant_rw   = grant_id ? req1_rw : req0_rw;
    take_grant = (state_reg == IDLE) && grant_valid;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          if (grant_rw) begin
            state_next = WR_SETUP;
          end else begin
            state_next = READ;
            cnt_next   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      READ: begin
        if (cnt_reg == '0) state_next = DONE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      WR_SETUP: begin
        state_next = WR_PULSE;
        cnt_next   = CNT_W'(WR_WAIT - 1);
      end
      WR_PULSE: begin
        if (cnt_reg == '0) state_next = WR_HOLD;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (take_grant) begin
        addr_reg       <= grant_id ? req1_addr  : req0_addr;
        wdata_reg      <= grant_id ? req1_wdata : req0_wdata;
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
      end
      // Capture on the edge that ends the final OE_N-low cycle.
      if (state_reg == READ && cnt_reg == '0) begin
        rdata_reg <= mem_data;
      end
    end
  end

  // Controls decode straight from the state register, so an asynchronous
  // reset releases WE_N/CE_N and the bus in the same instant.
  always_comb begin
    CE_N      = !((state_reg == READ) || (state_reg == WR_SETUP) ||
                  (state_reg == WR_PULSE) || (state_reg == WR_HOLD));
    OE_N      = (state_reg != READ);
    WE_N      = (state_reg != WR_PULSE);
    bus_drive = (state_reg == WR_SETUP) || (state_reg == WR_PULSE) ||
                (state_reg == WR_HOLD);
  end

  assign LB_N       = CE_N;
  assign UB_N       = CE_N;
  assign mem_addr   = addr_reg;
  assign mem_data   = bus_drive ? wdata_reg : {DATA_W{1'bz}};
  assign req0_ready = (state_reg == DONE) && !id_reg;
  assign req1_ready = (state_reg == DONE) &&  id_reg;
  assign req0_rdata = rdata_reg;
  assign req1_rdata = rdata_reg;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: small SRAM model on the bus, per-port
// scoreboard queues of expected completions (cycle and read data).
module tb_sram_arbiter_ctrl;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 64;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  localparam int RD_LAT  = RD_WAIT + 1;
  localparam int WR_LAT  = WR_WAIT + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0, req0_rw = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_wdata = '0;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_rdata;
  logic              req1_valid = 1'b0, req1_rw = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_wdata = '0;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_rdata;
  logic              CE_N, OE_N, WE_N, LB_N, UB_N;
  logic [ADDR_W-1:0] mem_addr;
  wire  [DATA_W-1:0] mem_data;

  sram_arbiter_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .LB_N(LB_N), .UB_N(UB_N),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: 8 words selected by {addr[19], addr[1:0]}.
  logic [DATA_W-1:0] sram [0:7];
  wire  [2:0]        sidx = {mem_addr[19], mem_addr[1:0]};
  assign mem_data = (!CE_N && !OE_N) ? sram[sidx] : {DATA_W{1'bz}};
  always @(posedge clk) if (!CE_N && !WE_N) sram[sidx] <= mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Undriven bus reads as Z in 4-state simulators and 0 in 2-state ones.
  function automatic logic bus_idle();
    return (mem_data === {DATA_W{1'bz}}) || (mem_data === {DATA_W{1'b0}});
  endfunction

  typedef struct {
    logic              rw;
    logic [DATA_W-1:0] rdata;
    int                cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Drive a request (call at posedge+1); lat<0 means no completion expected.
  task automatic start_req(input int port, input logic rw, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                           input int lat);
    exp_t e;
    if (port == 0) begin
      req0_valid = 1'b1; req0_rw = rw; req0_addr = addr; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_rw = rw; req1_addr = addr; req1_wdata = wd;
    end
    if (lat >= 0) begin
      e.rw = rw; e.rdata = exp_rd; e.cyc = cyc + lat;
      if (port == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
  endtask

  // Wait (bounded) for own ready, then release valid after the next edge.
  task automatic wait_done(input int port);
    int   n = 0;
    logic seen;
    seen = (port == 0) ? req0_ready : req1_ready;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = (port == 0) ? req0_ready : req1_ready;
    end
    check($sformatf("p%0d_ready_timeout", port), !seen, 1'b0);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  // Completion monitor: pops the port's scoreboard on every ready pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (!OE_N) begin
        check("rd_bus_contention", mem_data, sram[sidx]);
        check("rd_we_n", WE_N, 1'b1);
      end
      if (req0_ready || req1_ready) begin
        exp_t e;
        check("single_ready", req0_ready & req1_ready, 1'b0);
        check("done_bus_idle", bus_idle(), 1'b1);
        check("done_oe_n", OE_N, 1'b1);
        check("done_ce_n", CE_N, 1'b1);
        if (req0_ready) begin
          check("ready0_expected", q0.size() > 0, 1'b1);
          if (q0.size() > 0) begin
            e = q0.pop_front();
            check("ready0_cycle", cyc, e.cyc);
            if (!e.rw) check("rdata0", req0_rdata, e.rdata);
            $display("txn port0 %s cycle %0d rdata %h", e.rw ? "WR" : "RD", cyc, req0_rdata);
          end
        end
        if (req1_ready) begin
          check("ready1_expected", q1.size() > 0, 1'b1);
          if (q1.size() > 0) begin
            e = q1.pop_front();
            check("ready1_cycle", cyc, e.cyc);
            if (!e.rw) check("rdata1", req1_rdata, e.rdata);
            $display("txn port1 %s cycle %0d rdata %h", e.rw ? "WR" : "RD", cyc, req1_rdata);
          end
        end
      end
    end
  end

  initial begin
    // Reset held 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_ce_n", CE_N, 1'b1);
    check("rst_oe_n", OE_N, 1'b1);
    check("rst_we_n", WE_N, 1'b1);
    check("rst_lb_n", LB_N, 1'b1);
    check("rst_ub_n", UB_N, 1'b1);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_bus_idle", bus_idle(), 1'b1);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_rdata0", req0_rdata, '0);
    check("rst_rdata1", req1_rdata, '0);

    // Single write with per-cycle control check.
    @(posedge clk); #1;
    start_req(0, 1'b1, 20'h00001, 64'h2, '0, WR_LAT);
    @(negedge clk);
    for (int i = 1; i <= WR_LAT; i++) begin
      @(negedge clk);
      check($sformatf("wr_we_n_c%0d", i), WE_N, (i == 2 || i == 3) ? 1'b0 : 1'b1);
      check($sformatf("wr_ce_n_c%0d", i), CE_N, (i <= 4) ? 1'b0 : 1'b1);
    end
    wait_done(0);
    check("sram_word1", sram[1], 64'h2);

    // Single read.
    start_req(0, 1'b0, 20'h00001, '0, 64'h2, RD_LAT);
    @(negedge clk);
    for (int i = 1; i <= RD_LAT; i++) begin
      @(negedge clk);
      check($sformatf("rd_oe_n_c%0d", i), OE_N, (i <= 2) ? 1'b0 : 1'b1);
    end
    wait_done(0);

    // Fresh reset so last_grant is back to 1, then contention.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    fork
      begin start_req(0, 1'b1, 20'h00000, 64'h5, '0, WR_LAT); wait_done(0); end
      begin start_req(1, 1'b1, 20'h80000, 64'h6, '0, 2*WR_LAT + 1); wait_done(1); end
    join
    check("sram_word0", sram[0], 64'h5);
    check("sram_word80000", sram[4], 64'h6);
    fork
      begin start_req(0, 1'b0, 20'h00000, '0, 64'h5, RD_LAT); wait_done(0); end
      begin start_req(1, 1'b0, 20'h80000, '0, 64'h6, 2*RD_LAT + 1); wait_done(1); end
    join

    // Write then immediate read of the same word.
    start_req(0, 1'b1, 20'h80000, 64'h7, '0, WR_LAT);
    wait_done(0);
    start_req(0, 1'b0, 20'h80000, '0, 64'h7, RD_LAT);
    wait_done(0);

    // Reset during WR_PULSE: no completion expected.
    start_req(0, 1'b1, 20'h00002, 64'h9, '0, -1);
    repeat (3) @(negedge clk);
    check("abort_we_low", WE_N, 1'b0);
    rst = 1'b1; #1;
    check("abort_we_n", WE_N, 1'b1);
    check("abort_ce_n", CE_N, 1'b1);
    check("abort_bus_idle", bus_idle(), 1'b1);
    check("abort_ready0", req0_ready, 1'b0);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    start_req(1, 1'b0, 20'h00001, '0, 64'h2, RD_LAT);
    wait_done(1);

    repeat (3) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
